// File: rtl/operand_fetch_unit.sv
// ============================================================================
// operand_fetch_unit: register-file read client with write-back forwarding,
// pending-write scoreboard, RAW/WAW stall and a registered execute bundle.
// Revision 1.0
// ============================================================================
`default_nettype none

module operand_fetch_unit #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_rs1,
  input  logic [ADDR_W-1:0]   in_rs2,
  input  logic [ADDR_W-1:0]   in_rd,
  input  logic                in_rd_en,
  output logic [ADDR_W-1:0]   rf_read_addr1,
  output logic [ADDR_W-1:0]   rf_read_addr2,
  input  logic [DATA_W-1:0]   rf_read_data1,
  input  logic [DATA_W-1:0]   rf_read_data2,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_op1,
  output logic [DATA_W-1:0]   out_op2,
  output logic [ADDR_W-1:0]   out_rd,
  output logic                out_rd_en,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_op1_q, out_op1_d;
  logic [DATA_W-1:0]   out_op2_q, out_op2_d;
  logic [ADDR_W-1:0]   out_rd_q, out_rd_d;
  logic                out_rd_en_q, out_rd_en_d;
  logic [NUM_REGS-1:0] busy_mask_q, busy_mask_d;
  logic                hazard;
  logic                accept;

  function automatic logic wb_hit(input logic [ADDR_W-1:0] x);
    return wb_valid && (wb_addr == x) && (x != '0);
  endfunction

  // A same-cycle write-back releases the pending bit it targets.
  function automatic logic busy(input logic [ADDR_W-1:0] x);
    return busy_mask_q[x] && !wb_hit(x);
  endfunction

  function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] x,
                                                input logic [DATA_W-1:0] rf);
    if (x == '0)     return '0;
    else if (wb_hit(x)) return wb_data;
    else             return rf;
  endfunction

  assign rf_read_addr1 = in_rs1;
  assign rf_read_addr2 = in_rs2;

  assign hazard = ((in_rs1 != '0) && busy(in_rs1)) ||
                  ((in_rs2 != '0) && busy(in_rs2)) ||
                  (in_rd_en && (in_rd != '0) && busy(in_rd));

  assign in_ready = !reset && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_rd_d    = out_rd_q;
    out_rd_en_d = out_rd_en_q;
    busy_mask_d = busy_mask_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_op1_d   = operand(in_rs1, rf_read_data1);
      out_op2_d   = operand(in_rs2, rf_read_data2);
      out_rd_d    = in_rd;
      out_rd_en_d = in_rd_en;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear first so a same-register set in this cycle wins.
    if (wb_valid && (wb_addr != '0)) busy_mask_d[wb_addr] = 1'b0;
    if (accept && in_rd_en && (in_rd != '0)) busy_mask_d[in_rd] = 1'b1;
    busy_mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_q    <= '0;
      out_rd_en_q <= 1'b0;
      busy_mask_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_rd_q    <= out_rd_d;
      out_rd_en_q <= out_rd_en_d;
      busy_mask_q <= busy_mask_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_rd    = out_rd_q;
  assign out_rd_en = out_rd_en_q;
  assign busy_mask = busy_mask_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch_unit.sv
// ============================================================================
// tb_operand_fetch_unit: directed stimulus with a queue-based bundle scoreboard.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_operand_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_rs1, in_rs2, in_rd;
  logic       in_rd_en;
  logic [2:0] rf_read_addr1, rf_read_addr2;
  logic [3:0] rf_read_data1, rf_read_data2;
  logic       wb_valid;
  logic [2:0] wb_addr;
  logic [3:0] wb_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_op1, out_op2;
  logic [2:0] out_rd;
  logic       out_rd_en;
  logic [7:0] busy_mask;

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_q[$];

  operand_fetch_unit #(.DATA_W(4), .ADDR_W(3), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_en(in_rd_en),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_en(out_rd_en),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Bundle is {op1, op2, rd, rd_en}; popped whenever the execute stage consumes.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bundle", {20'h0, out_op1, out_op2, out_rd, out_rd_en}, 32'hFFFF_FFFF);
      end else begin
        chk("bundle", {20'h0, out_op1, out_op2, out_rd, out_rd_en}, {20'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and hold it until accepted; returns stall cycles.
  task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                       input logic en, input logic [3:0] d1, input logic [3:0] d2,
                       input logic [3:0] e1, input logic [3:0] e2, output int waited);
    logic done;
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_en = en;
    rf_read_data1 = d1; rf_read_data2 = d2;
    waited = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({e1, e2, rd, en});
        done = 1'b1;
      end else if (waited >= 20) begin
        chk("issue_timeout", 32'(waited), 32'd0);
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1; in_valid = 1'b1; in_rs1 = 3'd2; in_rs2 = 3'd3; in_rd = 3'd0; in_rd_en = 1'b0;
    rf_read_data1 = 4'd5; rf_read_data2 = 4'd6;
    wb_valid = 1'b0; wb_addr = 3'd0; wb_data = 4'd0; out_ready = 1'b1;
    step(); step();
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy_mask), 32'h00);
    chk("reset_ops", {24'h0, out_op1, out_op2}, 32'h00);
    reset = 1'b0;

    // Basic issue with 1-cycle latency
    issue(3'd2, 3'd3, 3'd0, 1'b0, 4'd5, 4'd6, 4'd5, 4'd6, w);
    chk("basic_no_stall", 32'(w), 32'd0);
    chk("basic_out_valid", 32'(out_valid), 32'd1);
    step();

    // RAW stall on r4, released by same-cycle write-back with forwarding
    issue(3'd1, 3'd1, 3'd4, 1'b1, 4'd1, 4'd1, 4'd1, 4'd1, w);
    chk("busy_r4", 32'(busy_mask), 32'h10);
    in_valid = 1'b1; in_rs1 = 3'd4; in_rs2 = 3'd0; in_rd = 3'd0; in_rd_en = 1'b0;
    rf_read_data1 = 4'd3; rf_read_data2 = 4'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("raw_stall", 32'(in_ready), 32'd0);
      step();
    end
    wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 4'd9;
    issue(3'd4, 3'd0, 3'd0, 1'b0, 4'd3, 4'd7, 4'd9, 4'd0, w);
    chk("raw_release_no_wait", 32'(w), 32'd0);
    wb_valid = 1'b0;
    @(negedge clk);
    chk("busy_cleared", 32'(busy_mask), 32'h00);
    step();

    // r0 sources read as zero; write-back to r0 never marks it busy
    wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 4'hF;
    issue(3'd0, 3'd0, 3'd0, 1'b1, 4'd7, 4'd7, 4'd0, 4'd0, w);
    chk("r0_no_stall", 32'(w), 32'd0);
    wb_valid = 1'b0;
    chk("r0_busy", 32'(busy_mask), 32'h00);
    step(); step();

    // Back-pressure: first bundle held stable, then drained in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 3'd1; in_rs2 = 3'd2; in_rd = 3'd0; in_rd_en = 1'b0;
    rf_read_data1 = 4'd1; rf_read_data2 = 4'd2;
    @(negedge clk);
    chk("bp_first_accept", 32'(in_ready), 32'd1);
    exp_q.push_back({4'd1, 4'd2, 3'd0, 1'b0});
    step();
    in_rs1 = 3'd3; in_rs2 = 3'd5; rf_read_data1 = 4'd3; rf_read_data2 = 4'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", {24'h0, 3'b0, out_valid, out_op1, out_op2}, 32'h112);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", 32'(in_ready), 32'd1);
    exp_q.push_back({4'd3, 4'd5, 3'd0, 1'b0});
    step();
    issue(3'd6, 3'd7, 3'd0, 1'b0, 4'd6, 4'd7, 4'd6, 4'd7, w);
    chk("bp_stream", 32'(w), 32'd0);
    step(); step();

    // Set wins over clear on the same register
    issue(3'd1, 3'd1, 3'd5, 1'b1, 4'd2, 4'd2, 4'd2, 4'd2, w);
    chk("busy_r5", 32'(busy_mask), 32'h20);
    wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 4'hA;
    issue(3'd0, 3'd0, 3'd5, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, w);
    chk("waw_release_no_wait", 32'(w), 32'd0);
    wb_valid = 1'b0;
    chk("set_wins", 32'(busy_mask), 32'h20);
    wb_valid = 1'b1; wb_addr = 3'd5;
    step();
    wb_valid = 1'b0;
    chk("r5_cleared", 32'(busy_mask), 32'h00);
    step();

    // Asynchronous reset while a bundle is held and writes are pending
    issue(3'd0, 3'd0, 3'd1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, w);
    issue(3'd0, 3'd0, 3'd2, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, w);
    out_ready = 1'b0;
    chk("pre_reset_state", {23'h0, out_valid, busy_mask}, 32'h106);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_busy", 32'(busy_mask), 32'h00);
    chk("async_reset_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    step();
    reset = 1'b0;
    out_ready = 1'b1;

    issue(3'd6, 3'd7, 3'd3, 1'b1, 4'd4, 4'd8, 4'd4, 4'd8, w);
    chk("post_reset_no_wait", 32'(w), 32'd0);
    step(); step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
